// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and default bit timing.
// Both the transmitter and the matching receiver import this package.
package uart_pkg;

  // 12 MHz reference clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // Parity-mode selector values
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Frame-level state encoding
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Parity bit for a data byte: XOR of all bits for even mode, inverted for odd
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps on every bit boundary.
// tick marks the final cycle of a bit period; tick_next marks the cycle before.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  // Free-running bit counter, held at zero while cleared so a frame starts on a clean period
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (i_Rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick      = (count == LAST);
  assign tick_next = (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// All outputs are registered; o_TX_Done is high on the last stop cycle of a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam logic HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic LAST_STOP  = 1'(STOP_BITS - 1);

  uart_state_t state;
  logic [7:0]  tx_data;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        tick;
  logic        tick_next;
  logic        timer_clear;

  // Timer restarts whenever the line is idle, so START always gets a full period
  assign timer_clear = (state == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .clear    (timer_clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // Frame sequencer with registered line, status and done outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      // NOTE: the latched byte is reset too, so a truncated frame leaves no
      // stale data behind and post-reset state is fully deterministic.
      state       <= ST_IDLE;
      tx_data     <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_TX_DV && o_TX_Ready) begin
            tx_data     <= i_TX_Byte;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            state       <= ST_START;
            o_TX_Ready  <= 1'b0;
            o_TX_Active <= 1'b1;
            o_TX_Serial <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state       <= ST_DATA;
            bit_idx     <= '0;
            o_TX_Serial <= tx_data[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              if (HAS_PARITY) begin
                state       <= ST_PARITY;
                o_TX_Serial <= parity_bit(tx_data, PARITY);
              end else begin
                state       <= ST_STOP;
                o_TX_Serial <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_TX_Serial <= tx_data[bit_idx + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state       <= ST_STOP;
            o_TX_Serial <= 1'b1;
          end
        end
        ST_STOP: begin
          // Done is registered, so it is raised one cycle early to land on the last stop cycle
          if (tick_next && (stop_idx == LAST_STOP)) begin
            o_TX_Done <= 1'b1;
          end
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state       <= ST_IDLE;
              o_TX_Active <= 1'b0;
              o_TX_Ready  <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        // NOTE: unused encodings recover to IDLE instead of hanging the line.
        default: begin
          state       <= ST_IDLE;
          o_TX_Ready  <= 1'b1;
          o_TX_Active <= 1'b0;
          o_TX_Serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four parameterisations share one clock and reset.
// Instance 0 default, 1 even parity, 2 odd parity, 3 two stop bits at 4 clocks/bit.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [3:0] dv;
  logic [7:0] tx_byte [4];
  logic [3:0] ready;
  logic [3:0] active;
  logic [3:0] serial;
  logic [3:0] done;

  int checks = 0;
  int errors = 0;

  // Per-cycle capture of one instance, index 0 = first START cycle
  logic line_log [0:4095];
  logic done_log [0:4095];
  logic act_log  [0:4095];
  logic rdy_log  [0:4095];

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         n;
    int         nbits;
    logic [11:0] frame;   // first transmitted bit at index nbits-1
    int         len;
    int         stop_run; // trailing high cycles at the end of the frame
  } vec_t;

  vec_t vecs [6];

  uart_tx u_def (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv[0]), .i_TX_Byte(tx_byte[0]),
    .o_TX_Ready(ready[0]), .o_TX_Active(active[0]), .o_TX_Serial(serial[0]), .o_TX_Done(done[0])
  );

  uart_tx #(.PARITY(1)) u_even (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv[1]), .i_TX_Byte(tx_byte[1]),
    .o_TX_Ready(ready[1]), .o_TX_Active(active[1]), .o_TX_Serial(serial[1]), .o_TX_Done(done[1])
  );

  uart_tx #(.PARITY(2)) u_odd (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv[2]), .i_TX_Byte(tx_byte[2]),
    .o_TX_Ready(ready[2]), .o_TX_Active(active[2]), .o_TX_Serial(serial[2]), .o_TX_Done(done[2])
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_s2 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv[3]), .i_TX_Byte(tx_byte[3]),
    .o_TX_Ready(ready[3]), .o_TX_Active(active[3]), .o_TX_Serial(serial[3]), .o_TX_Done(done[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Log ncyc cycles of one instance at negedges; mode 1 re-requests 0x0F when Ready
  // rises, mode 2 pulses DV with 0xFF at cycle 300, mode 3 pulses reset at cycle 300.
  task automatic capture(input int inst, input int ncyc, input int mode);
    bit requested = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      line_log[c] = serial[inst];
      done_log[c] = done[inst];
      act_log[c]  = active[inst];
      rdy_log[c]  = ready[inst];
      if (mode == 1) begin
        if (rdy_log[c] && !requested) begin
          dv[inst]      = 1'b1;
          tx_byte[inst] = 8'h0F;
          requested     = 1'b1;
        end else begin
          dv[inst] = 1'b0;
        end
      end else if (mode == 2) begin
        dv[inst] = (c == 300);
        if (c == 300) tx_byte[inst] = 8'hFF;
      end else if (mode == 3) begin
        rst = (c == 300);
      end
      @(negedge clk);
    end
    dv[inst] = 1'b0;
    rst      = 1'b0;
  endtask

  // Request a frame and wait until its first START cycle is at the current negedge
  task automatic launch(input int inst, input logic [7:0] data);
    @(negedge clk);
    dv[inst]      = 1'b1;
    tx_byte[inst] = data;
    @(negedge clk);
    dv[inst]      = 1'b0;
    tx_byte[inst] = ~data;  // must not disturb the latched byte
  endtask

  function automatic logic [11:0] decode(input int base, input int n, input int nbits);
    logic [11:0] bits = '0;
    for (int i = 0; i < nbits; i++) bits[nbits-1-i] = line_log[base + i*n + n/2];
    return bits;
  endfunction

  function automatic int count_done(input int from, input int upto);
    int k = 0;
    for (int c = from; c < upto; c++) if (done_log[c]) k++;
    return k;
  endfunction

  function automatic int first_done(input int from, input int upto);
    for (int c = from; c < upto; c++) if (done_log[c]) return c;
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    int run;
    int c;
    launch(v.inst, v.data);
    capture(v.inst, v.len + 20, 0);
    check("frame_bits", decode(0, v.n, v.nbits), v.frame);
    check("start_active", act_log[0], 1'b1);
    check("done_count", count_done(0, v.len + 20), 1);
    check("done_cycle", first_done(0, v.len + 20) + 1, v.len);
    run = 0;
    c   = v.len - 1;
    while (c >= 0 && line_log[c]) begin
      run++;
      c--;
    end
    check("stop_run", run, v.stop_run);
    check("active_last", act_log[v.len-1], 1'b1);
    check("idle_after", {act_log[v.len], rdy_log[v.len], line_log[v.len]}, 3'b011);
  endtask

  initial begin
    int   s2;
    int   gap;
    int   zeros;
    vec_t v5a;

    vecs[0] = '{inst:0, data:8'h55, n:104, nbits:10, frame:12'b00_0_10101010_1,  len:1040, stop_run:104};
    vecs[1] = '{inst:1, data:8'h01, n:104, nbits:11, frame:12'b0_0_10000000_1_1, len:1144, stop_run:208};
    vecs[2] = '{inst:1, data:8'h03, n:104, nbits:11, frame:12'b0_0_11000000_0_1, len:1144, stop_run:104};
    vecs[3] = '{inst:2, data:8'h01, n:104, nbits:11, frame:12'b0_0_10000000_0_1, len:1144, stop_run:104};
    vecs[4] = '{inst:2, data:8'h03, n:104, nbits:11, frame:12'b0_0_11000000_1_1, len:1144, stop_run:208};
    vecs[5] = '{inst:3, data:8'h35, n:4,   nbits:11, frame:12'b0_0_10101100_1_1, len:44,   stop_run:8};
    v5a     = '{inst:0, data:8'h5A, n:104, nbits:10, frame:12'b00_0_01011010_1,  len:1040, stop_run:104};

    // Reset, with DV held on instance 0 during the last reset cycle
    rst = 1'b1;
    dv  = '0;
    for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
    repeat (3) @(negedge clk);
    dv[0]      = 1'b1;
    tx_byte[0] = 8'hC3;
    @(negedge clk);
    rst = 1'b0;
    dv  = '0;
    check("rst_ready", ready, 4'hF);
    check("rst_active", active, 4'h0);
    check("rst_serial", serial, 4'hF);
    check("rst_done", done, 4'h0);
    @(negedge clk);
    check("dv_in_rst_ignored", {ready[0], active[0], serial[0]}, 3'b101);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: 0xA3 then 0x0F requested on the cycle Ready rises
    launch(0, 8'hA3);
    capture(0, 2100, 1);
    check("b2b_first", decode(0, 104, 10), 12'b00_0_11000101_1);
    s2 = -1;
    for (int c = 1040; c < 2100; c++) if (s2 < 0 && !line_log[c]) s2 = c;
    check("b2b_second_start", s2, 1041);
    gap = 0;
    for (int c = 1040; c < 2100 && c < s2; c++) if (line_log[c]) gap++;
    check("b2b_idle_gap", gap, 1);
    if (s2 >= 0 && s2 < 1050) begin
      check("b2b_second", decode(s2, 104, 10), 12'b00_0_11110000_1);
      check("b2b_done2_cycle", first_done(s2, 2100) - s2 + 1, 1040);
    end else begin
      check("b2b_second_found", 1'b0, 1'b1);
    end
    check("b2b_done_count", count_done(0, 2100), 2);

    // DV with 0xFF during a 0x00 frame must be ignored
    launch(0, 8'h00);
    capture(0, 1300, 2);
    check("busy_dv_frame", decode(0, 104, 10), 12'b00_0_00000000_1);
    check("busy_dv_done_count", count_done(0, 1300), 1);
    zeros = 0;
    for (int c = 1040; c < 1300; c++) if (!line_log[c]) zeros++;
    check("busy_dv_no_second", zeros, 0);
    check("busy_dv_idle", {act_log[1299], rdy_log[1299]}, 2'b01);

    // Reset mid-DATA truncates the frame without Done
    launch(0, 8'h33);
    capture(0, 1200, 3);
    check("midrst_data_state", {act_log[300], rdy_log[300]}, 2'b10);
    check("midrst_serial", line_log[301], 1'b1);
    check("midrst_ready", rdy_log[301], 1'b1);
    check("midrst_active", act_log[301], 1'b0);
    check("midrst_no_done", count_done(0, 1200), 0);
    zeros = 0;
    for (int c = 301; c < 1200; c++) if (!line_log[c]) zeros++;
    check("midrst_line_idle", zeros, 0);
    run_vec(v5a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
